// File: rtl/mem_pkg.sv
// Shared types and default constants for the slow main-memory responder.
package mem_pkg;

    // Responder sequencing: wait for a request, count out the access latency,
    // then present the single-cycle completion pulse.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mem_state_t;

    localparam int DEF_ADDR_WIDTH  = 28;
    localparam int DEF_BLOCK_WIDTH = 128;
    localparam int DEF_DEPTH_LOG2  = 8;
    localparam int DEF_LATENCY     = 4;

    // Latency counter width; covers LATENCY up to 255.
    localparam int CNT_WIDTH = 8;

endpackage

// File: rtl/mem_array.sv
// Line storage: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset; unwritten lines read as X.
module mem_array
    import mem_pkg::*;
#(
    parameter int DEPTH_LOG2  = DEF_DEPTH_LOG2,
    parameter int BLOCK_WIDTH = DEF_BLOCK_WIDTH
) (
    input  logic                   clk,
    input  logic                   we,
    input  logic [DEPTH_LOG2-1:0]  waddr,
    input  logic [BLOCK_WIDTH-1:0] wdata,
    input  logic [DEPTH_LOG2-1:0]  raddr,
    output logic [BLOCK_WIDTH-1:0] rdata
);

    logic [BLOCK_WIDTH-1:0] mem [0:(1<<DEPTH_LOG2)-1];

    // Commit a line on the rising edge when the write enable is set.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/slow_mem.sv
// Fixed-latency main-memory responder for the cache line-fill/write-back bus.
//
// Handshake: the initiator raises mem_read or mem_write (with address and
// data) and holds it until mem_ready. A request is sampled only in IDLE; once
// accepted it is latched, so later changes to the inputs (including dropping
// the request) do not affect it. mem_ready is a registered single-cycle pulse
// LATENCY cycles after acceptance, and mem_rdata is valid in that cycle for a
// read. The cycle after mem_ready is IDLE again, so a held follow-on request
// is accepted one cycle after the pulse. If read and write are both high at
// acceptance the write is performed and the read is dropped.
module slow_mem
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int BLOCK_WIDTH = DEF_BLOCK_WIDTH,
    parameter int DEPTH_LOG2  = DEF_DEPTH_LOG2,
    parameter int LATENCY     = DEF_LATENCY
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   mem_read,
    input  logic                   mem_write,
    input  logic [ADDR_WIDTH-1:0]  mem_addr,
    input  logic [BLOCK_WIDTH-1:0] mem_wdata,
    output logic [BLOCK_WIDTH-1:0] mem_rdata,
    output logic                   mem_ready
);

    localparam logic [CNT_WIDTH-1:0] CNT_LOAD = CNT_WIDTH'(LATENCY - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    mem_state_t             state_q, state_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   op_write_q;
    logic [DEPTH_LOG2-1:0]  idx_q;
    logic [BLOCK_WIDTH-1:0] wdata_q;
    logic [BLOCK_WIDTH-1:0] rdata_q;
    logic                   ready_q;

    logic                   accept;
    logic                   commit;
    logic                   cur_write;
    logic [DEPTH_LOG2-1:0]  cur_idx;
    logic [BLOCK_WIDTH-1:0] cur_wdata;
    logic [BLOCK_WIDTH-1:0] arr_rdata;
    logic                   arr_we;

    // Address bits above the index alias onto the same line.
    logic unused_addr_hi;
    assign unused_addr_hi = ^mem_addr[ADDR_WIDTH-1:DEPTH_LOG2];

    // With LATENCY=1 the commit happens on the acceptance edge itself, so the
    // operation is taken straight from the inputs instead of the latches.
    always_comb begin
        cur_write = op_write_q;
        cur_idx   = idx_q;
        cur_wdata = wdata_q;
        if (state_q == ST_IDLE) begin
            cur_write = mem_write;
            cur_idx   = mem_addr[DEPTH_LOG2-1:0];
            cur_wdata = mem_wdata;
        end
    end

    // Next-state, counter and commit decode.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        commit  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (mem_read || mem_write) begin
                    accept = 1'b1;
                    if (LATENCY == 1) begin
                        state_d = ST_DONE;
                        commit  = 1'b1;
                    end else begin
                        state_d = ST_BUSY;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            ST_BUSY: begin
                if (cnt_q == CNT_ONE) begin
                    state_d = ST_DONE;
                    cnt_d   = '0;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // A reset on the commit edge must keep an uncommitted write out of the array.
    assign arr_we = commit && cur_write && rst_n;

    mem_array #(
        .DEPTH_LOG2  (DEPTH_LOG2),
        .BLOCK_WIDTH (BLOCK_WIDTH)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .waddr (cur_idx),
        .wdata (cur_wdata),
        .raddr (cur_idx),
        .rdata (arr_rdata)
    );

    // State, counter, request latches and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            op_write_q <= 1'b0;
            idx_q      <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            ready_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= commit;
            if (accept) begin
                op_write_q <= mem_write;
                idx_q      <= mem_addr[DEPTH_LOG2-1:0];
                wdata_q    <= mem_wdata;
            end
            if (commit && !cur_write) begin
                rdata_q <= arr_rdata;
            end
        end
    end

    assign mem_rdata = rdata_q;
    assign mem_ready = ready_q;

endmodule

// File: tb/tb_slow_mem.sv
// Self-checking bench for slow_mem: a LATENCY=4 instance for most scenarios and
// a LATENCY=1 instance for the single-cycle build.
module tb_slow_mem;

    localparam int AW  = 28;
    localparam int BW  = 128;
    localparam int LAT = 4;

    logic          clk;
    logic          rst_n;
    logic          mem_read, mem_write;
    logic [AW-1:0] mem_addr;
    logic [BW-1:0] mem_wdata, mem_rdata;
    logic          mem_ready;

    logic          m1_read, m1_write;
    logic [AW-1:0] m1_addr;
    logic [BW-1:0] m1_wdata, m1_rdata;
    logic          m1_ready;

    int n_vec;
    int n_err;
    int cyc;

    // Reference model: line store indexed by low 8 address bits, plus the
    // last line returned by a read.
    logic [BW-1:0] ref_mem [0:255];
    bit            ref_vld [0:255];
    logic [BW-1:0] ref_rdata;
    logic [BW-1:0] exp_q [$];

    slow_mem #(.ADDR_WIDTH(AW), .BLOCK_WIDTH(BW), .DEPTH_LOG2(8), .LATENCY(LAT)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
    );

    slow_mem #(.ADDR_WIDTH(AW), .BLOCK_WIDTH(BW), .DEPTH_LOG2(8), .LATENCY(1)) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .mem_read  (m1_read),
        .mem_write (m1_write),
        .mem_addr  (m1_addr),
        .mem_wdata (m1_wdata),
        .mem_rdata (m1_rdata),
        .mem_ready (m1_ready)
    );

    // Clock and cycle counter.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Model update for one completed operation; write wins over read.
    task automatic model_op(input logic rd, input logic wr, input logic [AW-1:0] a,
                            input logic [BW-1:0] wd);
        int i;
        i = int'(a[7:0]);
        if (wr) begin
            ref_mem[i] = wd;
            ref_vld[i] = 1'b1;
        end else if (rd) begin
            ref_rdata = ref_mem[i];
        end
    endtask

    // Driver: present a request (held until ready), then drop it. Returns the
    // cycles from acceptance to ready (-1 on timeout), the read data and cycle
    // number at the pulse, and the ready level in the following cycle.
    task automatic do_req(input logic rd, input logic wr, input logic [AW-1:0] a,
                          input logic [BW-1:0] wd, output int lat,
                          output logic [BW-1:0] rdat, output int rcyc,
                          output logic ready_after);
        mem_read  = rd;
        mem_write = wr;
        mem_addr  = a;
        mem_wdata = wd;
        lat  = -1;
        rdat = 'x;
        rcyc = -1;
        for (int k = 1; k <= LAT + 8; k++) begin
            @(posedge clk); #1;
            if (mem_ready) begin
                lat  = k;
                rdat = mem_rdata;
                rcyc = cyc;
                break;
            end
        end
        mem_read  = 1'b0;
        mem_write = 1'b0;
        @(posedge clk); #1;
        ready_after = mem_ready;
    endtask

    task automatic do_req1(input logic rd, input logic wr, input logic [AW-1:0] a,
                           input logic [BW-1:0] wd, output int lat,
                           output logic [BW-1:0] rdat, output int rcyc);
        m1_read  = rd;
        m1_write = wr;
        m1_addr  = a;
        m1_wdata = wd;
        lat  = -1;
        rdat = 'x;
        rcyc = -1;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            if (m1_ready) begin
                lat  = k;
                rdat = m1_rdata;
                rcyc = cyc;
                break;
            end
        end
        m1_read  = 1'b0;
        m1_write = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        ref_rdata = '0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            n_vec++;
            if (mem_ready !== 1'b0 || mem_rdata !== '0) begin
                n_err++;
                $display("FAIL reset_idle cyc%0d: ready=%b rdata=%h, required ready=0 rdata=0",
                         k, mem_ready, mem_rdata);
            end
        end
    endtask

    task automatic test_write_read();
        logic [BW-1:0] d;
        logic [BW-1:0] rdat;
        int lat, rc;
        logic ra;
        d = 128'h0123456789ABCDEF0123456789ABCDEF;
        do_req(1'b0, 1'b1, 28'h0000005, d, lat, rdat, rc, ra);
        model_op(1'b0, 1'b1, 28'h0000005, d);
        n_vec++;
        if (lat !== LAT || ra !== 1'b0 || rdat !== ref_rdata) begin
            n_err++;
            $display("FAIL write_lat: lat=%0d ready_after=%b rdata=%h, required lat=%0d ready_after=0 rdata=%h",
                     lat, ra, rdat, LAT, ref_rdata);
        end
        do_req(1'b1, 1'b0, 28'h0000005, '0, lat, rdat, rc, ra);
        model_op(1'b1, 1'b0, 28'h0000005, '0);
        n_vec++;
        if (lat !== LAT || ra !== 1'b0 || rdat !== ref_rdata) begin
            n_err++;
            $display("FAIL read_back: lat=%0d ready_after=%b rdata=%h, required lat=%0d ready_after=0 rdata=%h",
                     lat, ra, rdat, LAT, ref_rdata);
        end
    endtask

    task automatic test_back_to_back();
        logic [BW-1:0] d7, d3, rdat;
        int lat, rc1, rc2;
        logic ra;
        d7 = {$urandom, $urandom, $urandom, $urandom};
        d3 = {$urandom, $urandom, $urandom, $urandom};
        do_req(1'b0, 1'b1, 28'h0000007, d7, lat, rdat, rc1, ra);
        model_op(1'b0, 1'b1, 28'h0000007, d7);
        // Write-back then fetch with no gap beyond the mandatory IDLE cycle.
        do_req(1'b0, 1'b1, 28'h1000003, d3, lat, rdat, rc1, ra);
        model_op(1'b0, 1'b1, 28'h1000003, d3);
        do_req(1'b1, 1'b0, 28'h0000007, '0, lat, rdat, rc2, ra);
        model_op(1'b1, 1'b0, 28'h0000007, '0);
        n_vec++;
        if (rc2 - rc1 !== LAT + 1) begin
            n_err++;
            $display("FAIL b2b_spacing: ready-to-ready=%0d, required %0d", rc2 - rc1, LAT + 1);
        end
        n_vec++;
        if (rdat !== ref_rdata || ra !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_fetch: rdata=%h ready_after=%b, required rdata=%h ready_after=0",
                     rdat, ra, ref_rdata);
        end
        // Line 3 reached through an aliased address.
        do_req(1'b1, 1'b0, 28'h0000003, '0, lat, rdat, rc2, ra);
        model_op(1'b1, 1'b0, 28'h0000003, '0);
        n_vec++;
        if (rdat !== ref_rdata) begin
            n_err++;
            $display("FAIL alias_line3: rdata=%h, required %h", rdat, ref_rdata);
        end
    endtask

    task automatic test_both_high();
        logic [BW-1:0] d, rdat;
        int lat, rc;
        logic ra;
        d = {$urandom, $urandom, $urandom, $urandom};
        do_req(1'b1, 1'b1, 28'h000000A, d, lat, rdat, rc, ra);
        model_op(1'b1, 1'b1, 28'h000000A, d);
        n_vec++;
        if (lat !== LAT || rdat !== ref_rdata) begin
            n_err++;
            $display("FAIL both_high: lat=%0d rdata=%h, required lat=%0d rdata=%h (unchanged)",
                     lat, rdat, LAT, ref_rdata);
        end
        do_req(1'b1, 1'b0, 28'h000000A, '0, lat, rdat, rc, ra);
        model_op(1'b1, 1'b0, 28'h000000A, '0);
        n_vec++;
        if (rdat !== ref_rdata) begin
            n_err++;
            $display("FAIL both_high_line: rdata=%h, required %h", rdat, ref_rdata);
        end
    endtask

    task automatic test_reset_mid();
        logic [BW-1:0] g, h, rdat;
        int lat, rc;
        logic ra;
        int pulses;
        g = {$urandom, $urandom, $urandom, $urandom};
        h = ~g;
        do_req(1'b0, 1'b1, 28'h000000B, g, lat, rdat, rc, ra);
        model_op(1'b0, 1'b1, 28'h000000B, g);
        mem_write = 1'b1;
        mem_addr  = 28'h000000B;
        mem_wdata = h;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n     = 1'b0;
        mem_write = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        ref_rdata = '0;
        pulses = 0;
        for (int k = 0; k < LAT + 3; k++) begin
            @(posedge clk); #1;
            if (mem_ready) pulses++;
        end
        n_vec++;
        if (pulses !== 0 || mem_rdata !== '0) begin
            n_err++;
            $display("FAIL reset_mid: pulses=%0d rdata=%h, required pulses=0 rdata=0",
                     pulses, mem_rdata);
        end
        do_req(1'b1, 1'b0, 28'h000000B, '0, lat, rdat, rc, ra);
        model_op(1'b1, 1'b0, 28'h000000B, '0);
        n_vec++;
        if (lat !== LAT || rdat !== ref_rdata) begin
            n_err++;
            $display("FAIL reset_mid_line: lat=%0d rdata=%h, required lat=%0d rdata=%h",
                     lat, rdat, LAT, ref_rdata);
        end
    endtask

    task automatic test_drop_request();
        logic [BW-1:0] d;
        int lat, pulses;
        d = {$urandom, $urandom, $urandom, $urandom};
        mem_write = 1'b1;
        mem_addr  = 28'h0000021;
        mem_wdata = d;
        @(posedge clk); #1;
        mem_write = 1'b0;
        mem_wdata = '0;
        model_op(1'b0, 1'b1, 28'h0000021, d);
        lat = -1;
        pulses = 0;
        for (int k = 2; k <= LAT + 4; k++) begin
            @(posedge clk); #1;
            if (mem_ready) begin
                pulses++;
                if (lat < 0) lat = k;
            end
        end
        n_vec++;
        if (lat !== LAT || pulses !== 1) begin
            n_err++;
            $display("FAIL drop_req: lat=%0d pulses=%0d, required lat=%0d pulses=1", lat, pulses, LAT);
        end
    endtask

    task automatic test_random();
        logic [BW-1:0] d, rdat, exp;
        logic [AW-1:0] a;
        logic rd, wr, ra;
        int lat, rc;
        for (int n = 0; n < 40; n++) begin
            a  = {AW'($urandom_range(0, 1023)) << 8} | AW'($urandom_range(0, 15));
            d  = {$urandom, $urandom, $urandom, $urandom};
            rd = ($urandom_range(0, 1) == 1) && ref_vld[a[7:0]];
            wr = !rd || ($urandom_range(0, 7) == 0);
            model_op(rd, wr, a, d);
            exp_q.push_back(ref_rdata);
            do_req(rd, wr, a, d, lat, rdat, rc, ra);
            exp = exp_q.pop_front();
            n_vec++;
            if (lat !== LAT || ra !== 1'b0 || rdat !== exp) begin
                n_err++;
                $display("FAIL random#%0d rd=%b wr=%b a=%h: lat=%0d ready_after=%b rdata=%h, required lat=%0d ready_after=0 rdata=%h",
                         n, rd, wr, a, lat, ra, rdat, LAT, exp);
            end
        end
    endtask

    task automatic test_latency1();
        logic [BW-1:0] d, rdat;
        int lat1, lat2, rc1, rc2;
        d = {$urandom, $urandom, $urandom, $urandom};
        do_req1(1'b0, 1'b1, 28'h0000044, d, lat1, rdat, rc1);
        // Cycle after the pulse is DONE->IDLE; the next request goes up there.
        @(posedge clk); #1;
        do_req1(1'b1, 1'b0, 28'h0000044, '0, lat2, rdat, rc2);
        n_vec++;
        if (lat1 !== 1 || lat2 !== 1 || rc2 - rc1 !== 2) begin
            n_err++;
            $display("FAIL lat1_timing: lat=%0d/%0d spacing=%0d, required 1/1 spacing=2",
                     lat1, lat2, rc2 - rc1);
        end
        n_vec++;
        if (rdat !== d) begin
            n_err++;
            $display("FAIL lat1_data: rdata=%h, required %h", rdat, d);
        end
        @(posedge clk); #1;
        n_vec++;
        if (m1_ready !== 1'b0) begin
            n_err++;
            $display("FAIL lat1_pulse_width: ready=%b, required 0", m1_ready);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        cyc = 0;
        rst_n = 1'b0;
        mem_read = 1'b0; mem_write = 1'b0; mem_addr = '0; mem_wdata = '0;
        m1_read = 1'b0;  m1_write = 1'b0;  m1_addr = '0;  m1_wdata = '0;
        for (int i = 0; i < 256; i++) ref_vld[i] = 1'b0;
        ref_rdata = '0;
        @(posedge clk); #1;
        test_reset();
        test_write_read();
        test_back_to_back();
        test_both_high();
        test_reset_mid();
        test_drop_request();
        test_random();
        test_latency1();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
